// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter that shares one AES decryption core among NUM_REQ requesters.
// It sequences the level start/done handshake, captures the result and aborts a hung core.
module aes_job_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 1023,
  localparam int unsigned IW         = $clog2(NUM_REQ),
  localparam int unsigned CW         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [128*NUM_REQ-1:0]   REQ_KEY,
  input  logic [128*NUM_REQ-1:0]   REQ_MSG,
  output logic [NUM_REQ-1:0]       RSP_VALID,
  input  logic [NUM_REQ-1:0]       RSP_READY,
  output logic [127:0]             RSP_DATA,
  output logic                     RSP_ERR,
  output logic                     AES_START,
  input  logic                     AES_DONE,
  output logic [127:0]             AES_KEY,
  output logic [127:0]             AES_MSG_ENC,
  input  logic [127:0]             AES_MSG_DEC,
  output logic                     BUSY,
  output logic [IW-1:0]            GRANT_ID
);

  localparam int unsigned DW = 128;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RESP, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win, grant_d;
  logic                found;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       key_d, msg_d, rsp_data_d;
  logic [NUM_REQ-1:0]  rsp_valid_d;
  logic                rsp_err_d, start_d, busy_d;

  // Winner search: first valid requester at or above the pointer, wrapping around
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && REQ_VALID[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = GRANT_ID;
    cnt_d       = cnt_q;
    key_d       = AES_KEY;
    msg_d       = AES_MSG_ENC;
    start_d     = AES_START;
    rsp_valid_d = RSP_VALID;
    rsp_data_d  = RSP_DATA;
    rsp_err_d   = RSP_ERR;
    REQ_READY   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          REQ_READY[win] = 1'b1;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (IW'(i) == win) begin
              key_d = REQ_KEY[i*DW +: DW];
              msg_d = REQ_MSG[i*DW +: DW];
            end
          end
          grant_d = win;
          ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        start_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving in the timeout cycle still completes the job normally
        if (AES_DONE) begin
          rsp_data_d            = AES_MSG_DEC;
          rsp_err_d             = 1'b0;
          rsp_valid_d           = '0;
          rsp_valid_d[GRANT_ID] = 1'b1;
          start_d               = 1'b0;
          state_d               = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          rsp_data_d            = '0;
          rsp_err_d             = 1'b1;
          rsp_valid_d           = '0;
          rsp_valid_d[GRANT_ID] = 1'b1;
          start_d               = 1'b0;
          state_d               = RESP;
        end
      end
      RESP: begin
        if (RSP_READY[GRANT_ID]) begin
          rsp_valid_d = '0;
          cnt_d       = '0;
          state_d     = AES_DONE ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!AES_DONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      GRANT_ID    <= '0;
      AES_KEY     <= '0;
      AES_MSG_ENC <= '0;
      AES_START   <= 1'b0;
      RSP_VALID   <= '0;
      RSP_DATA    <= '0;
      RSP_ERR     <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      GRANT_ID    <= grant_d;
      AES_KEY     <= key_d;
      AES_MSG_ENC <= msg_d;
      AES_START   <= start_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_DATA    <= rsp_data_d;
      RSP_ERR     <= rsp_err_d;
      BUSY        <= busy_d;
    end
  end

endmodule
